control_alarma: RTL and testbench
=================================

Name: control_alarma

Overview:
Alarm sequencing controller for the alarm clock. It holds the alarm time loaded by the setting block and compares it with the running time on each minute tick. It drives the buzzer and handles stop, snooze and auto-timeout. It sits between the setting block (ore/minute/load_alarma), the timekeeping counter (current time, minute tick) and the buzzer/LED outputs.

Parameters:
DURATA_SONERIE, 5, minutes the buzzer rings before auto-stop (1..59)
DURATA_AMANARE, 9, snooze length in minutes (1..59)
MAX_AMANARI, 3, maximum snoozes per alarm event (1..7)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
ore_timp  input  5  current hour, 0..23
minute_timp  input  6  current minute, 0..59
tick_minut  input  1  one-cycle pulse; asserted in the cycle where ore_timp/minute_timp already show the new minute
load_alarma  input  1  one-cycle pulse: latch ore_in/minute_in as alarm time
ore_in  input  5  alarm hour from setting block
minute_in  input  6  alarm minute from setting block
semnal_activare  input  1  one-cycle pulse: toggle alarm on/off
semnal_stop  input  1  one-cycle pulse: stop ringing/snooze
semnal_amanare  input  1  one-cycle pulse: snooze request
sonerie  output  1  buzzer drive, registered
alarma_armata  output  1  high in ARMED, RINGING, SNOOZE
ore_alarma  output  5  stored alarm hour
minute_alarma  output  6  stored alarm minute
stare  output  2  OFF=00, ARMED=01, RINGING=10, SNOOZE=11

Behaviour:
- All outputs are registered. Every input takes effect on the next rising edge, so outputs change one cycle after the input.
- Reset values: stare=OFF, sonerie=0, alarma_armata=0, ore_alarma=0, minute_alarma=0, ring-minute counter=0, snooze counter=0, snooze target=00:00.
- Priority per cycle: reset > load_alarma > semnal_activare > semnal_stop > semnal_amanare > tick_minut events.
- load_alarma, valid input (ore_in<=23 and minute_in<=59):
  - latch the alarm time, stare->ARMED, clear snooze and ring counters, sonerie->0.
  - Applies from any state.
- load_alarma, invalid input: ignored entirely; state and registers are unchanged.
- semnal_activare: OFF->ARMED; ARMED, RINGING or SNOOZE->OFF. Leaving RINGING or SNOOZE this way also clears the counters and drops sonerie.
- OFF: only load_alarma and semnal_activare have effect.
- ARMED: on tick_minut with ore_timp==ore_alarma and minute_timp==minute_alarma:
  - stare->RINGING, sonerie->1, ring counter=0.
  - A match without tick_minut does not trigger.
- RINGING, each tick_minut: ring counter+1. When it reaches DURATA_SONERIE: stare->ARMED, sonerie->0, snooze counter=0.
- RINGING, semnal_stop: ->ARMED, sonerie->0, counters cleared. The alarm stays armed for the next day.
- RINGING, semnal_amanare with snooze counter<MAX_AMANARI:
  - snooze target = current time + DURATA_AMANARE, minutes mod 60 with carry into hours mod 24.
  - snooze counter+1, ->SNOOZE, sonerie->0.
- RINGING, semnal_amanare with snooze counter==MAX_AMANARI: ignored; keeps ringing.
- SNOOZE: on tick_minut with current time == snooze target: ->RINGING, sonerie->1, ring counter=0.
- SNOOZE, semnal_stop: ->ARMED, counters cleared.
- SNOOZE, semnal_amanare: ignored.
- Simultaneous semnal_stop and the timeout tick in RINGING: the stop result applies. The final state is ARMED either way.
- Simultaneous semnal_amanare and the timeout tick: the snooze wins, ->SNOOZE.
- Reset mid-ring returns everything to the reset values; the alarm time is lost.
- stare encoding uses no illegal states. Any unexpected encoding returns to OFF on the next edge.

Test Plan:
1. Reset, then load 07:30, then tick with time 07:29 -> stare=ARMED, sonerie=0. Tick with time 07:30 -> next cycle stare=RINGING, sonerie=1.
2. Ringing with no input, 5 further ticks -> after the 5th tick stare=ARMED, sonerie=0. The same time one day later rings again.
3. Alarm 23:55 ringing, snooze at time 23:55 -> stare=SNOOZE, target 00:04. Tick at 00:03 -> still SNOOZE. Tick at 00:04 -> RINGING.
4. Snooze 3 times, then a 4th semnal_amanare -> stays RINGING, sonerie=1. semnal_stop -> ARMED, snooze counter 0.
5. Load ore_in=24, minute_in=10 -> ignored; ore_alarma/minute_alarma keep their previous values. Load 06:60 -> ignored.
6. While RINGING, pulse semnal_activare and semnal_stop together -> stare=OFF, sonerie=0. A later matching tick does not ring. Assert reset while in SNOOZE -> all outputs return to zero the next cycle.

Source files
------------

// File: rtl/control_alarma_if.sv
// Signal bundle between the alarm controller and its neighbours:
// the time source, the setting block and the buzzer/LED outputs.
interface control_alarma_if;
  logic [4:0] ore_timp;
  logic [5:0] minute_timp;
  logic       tick_minut;
  logic       load_alarma;
  logic [4:0] ore_in;
  logic [5:0] minute_in;
  logic       semnal_activare;
  logic       semnal_stop;
  logic       semnal_amanare;
  logic       sonerie;
  logic       alarma_armata;
  logic [4:0] ore_alarma;
  logic [5:0] minute_alarma;
  logic [1:0] stare;

  modport master (
    output ore_timp, minute_timp, tick_minut, load_alarma, ore_in, minute_in,
           semnal_activare, semnal_stop, semnal_amanare,
    input  sonerie, alarma_armata, ore_alarma, minute_alarma, stare
  );

  modport slave (
    input  ore_timp, minute_timp, tick_minut, load_alarma, ore_in, minute_in,
           semnal_activare, semnal_stop, semnal_amanare,
    output sonerie, alarma_armata, ore_alarma, minute_alarma, stare
  );
endinterface

// File: rtl/control_alarma.sv
// Alarm sequencer: stores the alarm time, rings on the matching minute tick,
// and handles stop, limited snoozes and the automatic ring timeout.
module control_alarma #(
  parameter int unsigned DURATA_SONERIE = 5,
  parameter int unsigned DURATA_AMANARE = 9,
  parameter int unsigned MAX_AMANARI    = 3
) (
  input  logic             clock,
  input  logic             reset,
  control_alarma_if.slave  bus
);

  typedef enum logic [1:0] {
    OFF     = 2'b00,
    ARMED   = 2'b01,
    RINGING = 2'b10,
    SNOOZE  = 2'b11
  } stare_t;

  localparam logic [5:0] DUR_S = 6'(DURATA_SONERIE);
  localparam logic [6:0] DUR_A = 7'(DURATA_AMANARE);
  localparam logic [2:0] MAX_A = 3'(MAX_AMANARI);

  stare_t     stare_q, stare_d;
  logic       sonerie_q, sonerie_d;
  logic       armata_q;
  logic [4:0] oreAl_q, oreAl_d;
  logic [5:0] minAl_q, minAl_d;
  logic [5:0] ringCnt_q, ringCnt_d;
  logic [2:0] snzCnt_q, snzCnt_d;
  logic [4:0] snzOre_q, snzOre_d;
  logic [5:0] snzMin_q, snzMin_d;

  logic       loadValid;
  logic       alarmMatch;
  logic       snoozeMatch;
  logic [6:0] minSum;
  logic [4:0] tgtOre;
  logic [5:0] tgtMin;

  assign loadValid   = bus.load_alarma && (bus.ore_in <= 5'd23) && (bus.minute_in <= 6'd59);
  assign alarmMatch  = (bus.ore_timp == oreAl_q) && (bus.minute_timp == minAl_q);
  assign snoozeMatch = (bus.ore_timp == snzOre_q) && (bus.minute_timp == snzMin_q);
  assign minSum      = {1'b0, bus.minute_timp} + DUR_A;

  // Snooze wake-up time: minutes wrap at 60 and carry into hours, which wrap at 24.
  always_comb begin
    tgtMin = minSum[5:0];
    tgtOre = bus.ore_timp;
    if (minSum >= 7'd60) begin
      tgtMin = 6'(minSum - 7'd60);
      tgtOre = (bus.ore_timp >= 5'd23) ? 5'd0 : bus.ore_timp + 5'd1;
    end
  end

  always_comb begin
    stare_d   = stare_q;
    sonerie_d = sonerie_q;
    oreAl_d   = oreAl_q;
    minAl_d   = minAl_q;
    ringCnt_d = ringCnt_q;
    snzCnt_d  = snzCnt_q;
    snzOre_d  = snzOre_q;
    snzMin_d  = snzMin_q;

    if (loadValid) begin
      oreAl_d   = bus.ore_in;
      minAl_d   = bus.minute_in;
      stare_d   = ARMED;
      sonerie_d = 1'b0;
      ringCnt_d = '0;
      snzCnt_d  = '0;
    end else if (bus.semnal_activare) begin
      stare_d   = (stare_q == OFF) ? ARMED : OFF;
      sonerie_d = 1'b0;
      ringCnt_d = '0;
      snzCnt_d  = '0;
    end else begin
      case (stare_q)
        OFF: ;
        ARMED: begin
          if (bus.tick_minut && alarmMatch) begin
            stare_d   = RINGING;
            sonerie_d = 1'b1;
            ringCnt_d = '0;
          end
        end
        // A snooze refused at the limit falls through, so the same tick can still time out.
        RINGING: begin
          if (bus.semnal_stop) begin
            stare_d   = ARMED;
            sonerie_d = 1'b0;
            ringCnt_d = '0;
            snzCnt_d  = '0;
          end else if (bus.semnal_amanare && (snzCnt_q < MAX_A)) begin
            stare_d   = SNOOZE;
            sonerie_d = 1'b0;
            snzCnt_d  = snzCnt_q + 3'd1;
            snzOre_d  = tgtOre;
            snzMin_d  = tgtMin;
          end else if (bus.tick_minut) begin
            ringCnt_d = ringCnt_q + 6'd1;
            if (ringCnt_q + 6'd1 == DUR_S) begin
              stare_d   = ARMED;
              sonerie_d = 1'b0;
              snzCnt_d  = '0;
            end
          end
        end
        SNOOZE: begin
          if (bus.semnal_stop) begin
            stare_d   = ARMED;
            sonerie_d = 1'b0;
            ringCnt_d = '0;
            snzCnt_d  = '0;
          end else if (bus.tick_minut && snoozeMatch) begin
            stare_d   = RINGING;
            sonerie_d = 1'b1;
            ringCnt_d = '0;
          end
        end
        default: begin
          stare_d   = OFF;
          sonerie_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stare_q   <= OFF;
      sonerie_q <= 1'b0;
      armata_q  <= 1'b0;
      oreAl_q   <= '0;
      minAl_q   <= '0;
      ringCnt_q <= '0;
      snzCnt_q  <= '0;
      snzOre_q  <= '0;
      snzMin_q  <= '0;
    end else begin
      stare_q   <= stare_d;
      sonerie_q <= sonerie_d;
      armata_q  <= (stare_d != OFF);
      oreAl_q   <= oreAl_d;
      minAl_q   <= minAl_d;
      ringCnt_q <= ringCnt_d;
      snzCnt_q  <= snzCnt_d;
      snzOre_q  <= snzOre_d;
      snzMin_q  <= snzMin_d;
    end
  end

  assign bus.stare         = stare_q;
  assign bus.sonerie       = sonerie_q;
  assign bus.alarma_armata = armata_q;
  assign bus.ore_alarma    = oreAl_q;
  assign bus.minute_alarma = minAl_q;

endmodule

// File: tb/tb_control_alarma.sv
// Bench for control_alarma: directed vector table, hand-written corner
// sequences, then random traffic checked against a minutes-of-day model.
module tb_control_alarma;
  localparam int DUR  = 5;
  localparam int SNZ  = 9;
  localparam int MAXS = 3;

  logic clock = 1'b0;
  logic reset;

  control_alarma_if bus();

  control_alarma #(
    .DURATA_SONERIE(DUR),
    .DURATA_AMANARE(SNZ),
    .MAX_AMANARI(MAXS)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model: times kept as minutes since midnight.
  int mSt, mAlarm, mTgt, mRing, mUsed;

  typedef struct {
    bit r, ld, act, stp, snz, tk;
    int hT, mT, hIn, mIn;
    int eSt;
    bit eSon;
    int eH, eM;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input bit r, ld, act, stp, snz, tk,
                              input int hT, mT, hIn, mIn, eSt,
                              input bit eSon, input int eH, eM);
    vec_t v;
    v.r = r; v.ld = ld; v.act = act; v.stp = stp; v.snz = snz; v.tk = tk;
    v.hT = hT; v.mT = mT; v.hIn = hIn; v.mIn = mIn;
    v.eSt = eSt; v.eSon = eSon; v.eH = eH; v.eM = eM;
    return v;
  endfunction

  task automatic modelStep(input bit r, ld, act, stp, snz, tk, input int hT, mT, hIn, mIn);
    int now;
    now = hT * 60 + mT;
    if (r) begin
      mSt = 0; mAlarm = 0; mTgt = 0; mRing = 0; mUsed = 0;
    end else if (ld && hIn <= 23 && mIn <= 59) begin
      mAlarm = hIn * 60 + mIn; mSt = 1; mRing = 0; mUsed = 0;
    end else if (act) begin
      mSt = (mSt == 0) ? 1 : 0; mRing = 0; mUsed = 0;
    end else if (mSt == 1) begin
      if (tk && now == mAlarm) begin mSt = 2; mRing = 0; end
    end else if (mSt == 2) begin
      if (stp) begin
        mSt = 1; mRing = 0; mUsed = 0;
      end else if (snz && mUsed < MAXS) begin
        mTgt = (now + SNZ) % 1440; mUsed++; mSt = 3;
      end else if (tk) begin
        mRing++;
        if (mRing == DUR) begin mSt = 1; mUsed = 0; end
      end
    end else if (mSt == 3) begin
      if (stp) begin
        mSt = 1; mRing = 0; mUsed = 0;
      end else if (tk && now == mTgt) begin
        mSt = 2; mRing = 0;
      end
    end
  endtask

  task automatic applyStimulus(input bit r, ld, act, stp, snz, tk, input int hT, mT, hIn, mIn);
    reset               = r;
    bus.load_alarma     = ld;
    bus.semnal_activare = act;
    bus.semnal_stop     = stp;
    bus.semnal_amanare  = snz;
    bus.tick_minut      = tk;
    bus.ore_timp        = 5'(hT);
    bus.minute_timp     = 6'(mT);
    bus.ore_in          = 5'(hIn);
    bus.minute_in       = 6'(mIn);
    modelStep(r, ld, act, stp, snz, tk, hT, mT, hIn, mIn);
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input int eSt, input bit eSon, input int eH, input int eM);
    bit ok;
    total++;
    ok = (bus.stare === 2'(eSt)) && (bus.sonerie === eSon) &&
         (bus.alarma_armata === (eSt != 0)) &&
         (bus.ore_alarma === 5'(eH)) && (bus.minute_alarma === 6'(eM));
    if (!ok) begin
      bad++;
      $display("[TB] FAIL %s: got stare=%0d sonerie=%0b armata=%0b alarm=%0d:%0d, want stare=%0d sonerie=%0b armata=%0b alarm=%0d:%0d",
               name, bus.stare, bus.sonerie, bus.alarma_armata, bus.ore_alarma, bus.minute_alarma,
               eSt, eSon, (eSt != 0), eH, eM);
    end
  endtask

  initial begin
    int nowMin;
    bit r, ld, act, stp, snz, tk;
    int hIn, mIn, cand;

    // reset, arm 07:30, ring, timeout, next-day ring, snooze across midnight
    tbl.push_back(mk(1,0,0,0,0,0,  0, 0,  0, 0, 0,0, 0, 0));
    tbl.push_back(mk(0,1,0,0,0,0,  7,29,  7,30, 1,0, 7,30));
    tbl.push_back(mk(0,0,0,0,0,1,  7,29,  0, 0, 1,0, 7,30));
    tbl.push_back(mk(0,0,0,0,0,0,  7,30,  0, 0, 1,0, 7,30));
    tbl.push_back(mk(0,0,0,0,0,1,  7,30,  0, 0, 2,1, 7,30));
    tbl.push_back(mk(0,0,0,0,0,1,  7,31,  0, 0, 2,1, 7,30));
    tbl.push_back(mk(0,0,0,0,0,1,  7,32,  0, 0, 2,1, 7,30));
    tbl.push_back(mk(0,0,0,0,0,1,  7,33,  0, 0, 2,1, 7,30));
    tbl.push_back(mk(0,0,0,0,0,1,  7,34,  0, 0, 2,1, 7,30));
    tbl.push_back(mk(0,0,0,0,0,1,  7,35,  0, 0, 1,0, 7,30));
    tbl.push_back(mk(0,0,0,0,0,1,  7,36,  0, 0, 1,0, 7,30));
    tbl.push_back(mk(0,0,0,0,0,1,  7,30,  0, 0, 2,1, 7,30));
    tbl.push_back(mk(0,0,0,1,0,0,  7,30,  0, 0, 1,0, 7,30));
    tbl.push_back(mk(0,1,0,0,0,0,  7,30, 23,55, 1,0,23,55));
    tbl.push_back(mk(0,0,0,0,0,0, 23,55,  0, 0, 1,0,23,55));
    tbl.push_back(mk(0,0,0,0,0,1, 23,55,  0, 0, 2,1,23,55));
    tbl.push_back(mk(0,0,0,0,1,0, 23,55,  0, 0, 3,0,23,55));
    tbl.push_back(mk(0,0,0,0,0,1,  0, 3,  0, 0, 3,0,23,55));
    tbl.push_back(mk(0,0,0,0,0,1,  0, 4,  0, 0, 2,1,23,55));

    foreach (tbl[i]) begin
      applyStimulus(tbl[i].r, tbl[i].ld, tbl[i].act, tbl[i].stp, tbl[i].snz, tbl[i].tk,
                    tbl[i].hT, tbl[i].mT, tbl[i].hIn, tbl[i].mIn);
      checkOutput($sformatf("vec%0d", i), tbl[i].eSt, tbl[i].eSon, tbl[i].eH, tbl[i].eM);
    end

    // snooze limit: one snooze already used, two more allowed, the fourth refused
    applyStimulus(0,0,0,0,1,0,  0, 4, 0, 0); checkOutput("snz2", 3,0,23,55);
    applyStimulus(0,0,0,0,0,1,  0,13, 0, 0); checkOutput("wake2", 2,1,23,55);
    applyStimulus(0,0,0,0,1,0,  0,13, 0, 0); checkOutput("snz3", 3,0,23,55);
    applyStimulus(0,0,0,0,0,1,  0,22, 0, 0); checkOutput("wake3", 2,1,23,55);
    applyStimulus(0,0,0,0,1,0,  0,22, 0, 0); checkOutput("snzLimit", 2,1,23,55);
    applyStimulus(0,0,0,1,0,0,  0,22, 0, 0); checkOutput("stopRing", 1,0,23,55);
    applyStimulus(0,0,0,0,0,1, 23,55, 0, 0); checkOutput("ringAgain", 2,1,23,55);
    applyStimulus(0,0,0,0,1,0, 23,55, 0, 0); checkOutput("snzAfterStop", 3,0,23,55);
    applyStimulus(0,0,0,1,0,0, 23,55, 0, 0); checkOutput("stopSnooze", 1,0,23,55);

    // invalid loads are ignored, 23:59 is the largest legal alarm
    applyStimulus(0,1,0,0,0,0, 23,55,24,10); checkOutput("badHour", 1,0,23,55);
    applyStimulus(0,1,0,0,0,0, 23,55, 6,60); checkOutput("badMin", 1,0,23,55);
    applyStimulus(0,1,0,0,0,0, 23,55,23,59); checkOutput("load2359", 1,0,23,59);

    // activare beats stop; then snooze carry into the next day; reset in SNOOZE
    applyStimulus(0,0,0,0,0,1, 23,59, 0, 0); checkOutput("ring2359", 2,1,23,59);
    applyStimulus(0,0,1,1,0,0, 23,59, 0, 0); checkOutput("actStop", 0,0,23,59);
    applyStimulus(0,0,0,0,0,1, 23,59, 0, 0); checkOutput("offNoRing", 0,0,23,59);
    applyStimulus(0,0,1,0,0,0, 23,59, 0, 0); checkOutput("reArm", 1,0,23,59);
    applyStimulus(0,0,0,0,0,1, 23,59, 0, 0); checkOutput("ring2", 2,1,23,59);
    applyStimulus(0,0,0,0,1,0, 23,59, 0, 0); checkOutput("snzCarry", 3,0,23,59);
    applyStimulus(0,0,0,0,0,1,  0, 7, 0, 0); checkOutput("early", 3,0,23,59);
    applyStimulus(0,0,0,0,0,1,  0, 8, 0, 0); checkOutput("wake0008", 2,1,23,59);
    applyStimulus(0,0,0,0,1,0,  0, 8, 0, 0); checkOutput("snzAgain", 3,0,23,59);
    applyStimulus(1,0,0,0,0,0,  0, 8, 0, 0); checkOutput("resetSnz", 0,0, 0, 0);

    // stop or snooze arriving together with the timeout tick
    applyStimulus(0,1,0,0,0,0,  9,59,10, 0); checkOutput("load1000", 1,0,10,0);
    applyStimulus(0,0,0,0,0,1, 10, 0, 0, 0); checkOutput("ring1000", 2,1,10,0);
    for (int m = 1; m <= DUR - 1; m++) begin
      applyStimulus(0,0,0,0,0,1, 10, m, 0, 0); checkOutput("ringing", 2,1,10,0);
    end
    applyStimulus(0,0,0,1,0,1, 10, DUR, 0, 0); checkOutput("stopTimeout", 1,0,10,0);
    applyStimulus(0,0,0,0,0,1, 10, 0, 0, 0); checkOutput("ring1000b", 2,1,10,0);
    for (int m = 1; m <= DUR - 1; m++) begin
      applyStimulus(0,0,0,0,0,1, 10, m, 0, 0); checkOutput("ringingB", 2,1,10,0);
    end
    applyStimulus(0,0,0,0,1,1, 10, DUR, 0, 0); checkOutput("snzTimeout", 3,0,10,0);
    applyStimulus(0,0,0,0,0,1, 10, DUR + SNZ, 0, 0); checkOutput("wakeTimeout", 2,1,10,0);

    // random traffic: minute ticks walk a running clock, alarms loaded near "now"
    nowMin = 10 * 60 + DUR + SNZ;
    for (int n = 0; n < 3000; n++) begin
      r   = ($urandom % 500) == 0;
      tk  = ($urandom % 2) == 0;
      if (tk) nowMin = (nowMin + 1) % 1440;
      ld  = ($urandom % 40) == 0;
      act = ($urandom % 60) == 0;
      stp = ($urandom % 25) == 0;
      snz = ($urandom % 6) == 0;
      hIn = 0;
      mIn = 0;
      if (ld) begin
        if (($urandom % 4) == 0) begin
          if (($urandom % 2) == 0) begin
            hIn = 24 + int'($urandom % 8);
            mIn = int'($urandom % 60);
          end else begin
            hIn = int'($urandom % 24);
            mIn = 60 + int'($urandom % 4);
          end
        end else begin
          cand = (nowMin + int'($urandom_range(1, 4))) % 1440;
          hIn  = cand / 60;
          mIn  = cand % 60;
        end
      end
      applyStimulus(r, ld, act, stp, snz, tk, nowMin / 60, nowMin % 60, hIn, mIn);
      checkOutput("rand", mSt, (mSt == 2), mAlarm / 60, mAlarm % 60);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
